// File: rtl/uart_tx_cfg_if.sv
// Write-side bus of the configurable UART transmitter: byte strobe/data in,
// FIFO status back to the register block.
interface uart_tx_cfg_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic             tx_we;
  logic [7:0]       din;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport master (output tx_we, output din,
                  input  full, input empty, input level, input overflow);
  modport slave  (input  tx_we, input din,
                  output full, output empty, output level, output overflow);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, optional parity,
// 1/2 stop bits) fed from an internal byte FIFO.
module uart_tx_cfg #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [15:0]   baud_div_i,
  input  logic [1:0]    data_bits_i,
  input  logic          parity_en_i,
  input  logic          parity_odd_i,
  input  logic          stop2_i,
  input  logic          tx_en_i,
  uart_tx_cfg_if.slave  wr,
  output logic          busy_o,
  output logic          done_o,
  output logic          tx_o
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DAT_W = 8;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [DAT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] count_q;
  logic             overflow_q;
  logic             full, empty, push, pop, can_start, bit_end;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, last_q, last_d;
  logic [BIT_W-1:0] bit_q, bit_d, data_last;
  logic [DAT_W-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [1:0]       dbits_q, dbits_d;
  logic             pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d;
  logic             tx_q, tx_d, done_q, done_d, busy_q;

  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = wr.tx_we && !full;
  assign can_start = !empty && tx_en_i;
  assign bit_end   = (cnt_q == last_q);
  assign data_last = {1'b1, dbits_q};

  assign wr.full     = full;
  assign wr.empty    = empty;
  assign wr.level    = count_q;
  assign wr.overflow = overflow_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tx_o        = tx_q;

  // Storage array carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr.din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr.tx_we && full;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + LVL_W'(1);
      else if (pop && !push) count_q <= count_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dbits_q <= '0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dbits_q <= dbits_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state logic; line level and done are computed for the next cycle so they leave flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + DIV_W'(1);
    last_d  = last_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    dbits_d = dbits_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    stop2_d = stop2_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        pop   = can_start;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_q == data_last) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && bit_q == '0) bit_d = BIT_W'(1);
          else if (can_start)         pop = 1'b1;
          else                        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: pop head and freeze the line configuration for this frame.
    if (pop) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = mem_q[rptr_q];
      par_d   = 1'b0;
      dbits_d = data_bits_i;
      pen_d   = parity_en_i;
      podd_d  = parity_odd_i;
      stop2_d = stop2_i;
      last_d  = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d ^ podd_d;
      default:  tx_d = 1'b1;
    endcase

    done_d = (state_d == S_STOP) && (cnt_d == last_d) && (bit_d == BIT_W'(stop2_d));
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomised scoreboard bench for uart_tx_cfg: expected frames are queued at
// write time and a line monitor checks every bit period and the done pulse.
module tb_uart_tx_cfg;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          div;
    logic [7:0]  data;
  } frame_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [15:0] baud_div_i = 16'd4;
  logic [1:0]  data_bits_i = 2'd3;
  logic parity_en_i = 1'b0, parity_odd_i = 1'b0, stop2_i = 1'b0, tx_en_i = 1'b0;
  logic busy_o, done_o, tx_o;

  uart_tx_cfg_if #(.FIFO_DEPTH(DEPTH)) wr_if ();

  uart_tx_cfg #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .baud_div_i(baud_div_i), .data_bits_i(data_bits_i),
    .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i), .stop2_i(stop2_i),
    .tx_en_i(tx_en_i), .wr(wr_if), .busy_o(busy_o), .done_o(done_o), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  frame_t exp_q[$];

  // Monitor state
  frame_t cur;
  bit in_frame = 0, ignore_low = 0;
  int fcyc = 0, cyc_no = 0, last_end = -10, b2b = 0, stray_done = 0;
  int first_bad, done_hits, done_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame built straight from the line format rules.
  function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic pen, input logic podd,
                                        input logic s2, input logic [15:0] div);
    frame_t f;
    int n = 5 + int'(db);
    int k = 0;
    logic p = 1'b0;
    f.bits = '1;
    f.data = d;
    f.bits[k++] = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[k++] = d[i];
      p ^= d[i];
    end
    if (pen) f.bits[k++] = p ^ podd;
    f.bits[k++] = 1'b1;
    if (s2) f.bits[k++] = 1'b1;
    f.nb  = k;
    f.div = (div == 0) ? 1 : int'(div);
    return f;
  endfunction

  always @(negedge clk) begin
    cyc_no++;
    if (rst_i) begin
      in_frame   = 0;
      ignore_low = 0;
    end else begin
      if (ignore_low && tx_o) ignore_low = 0;
      if (!in_frame) begin
        if (done_o) stray_done++;
        if (tx_o == 1'b0 && !ignore_low) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: line went low at cycle %0d with nothing queued", cyc_no);
            ignore_low = 1;
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1; fcyc = 0; first_bad = -1; done_hits = 0; done_at = -1;
            if (cyc_no == last_end + 1) b2b++;
          end
        end
      end
      if (in_frame) begin
        if (tx_o !== cur.bits[fcyc / cur.div] && first_bad < 0) first_bad = fcyc;
        if (done_o) begin done_hits++; done_at = fcyc; end
        fcyc++;
        if (fcyc == cur.nb * cur.div) begin
          chk($sformatf("frame_bits d=%02h first_bad_cycle", cur.data), 32'(first_bad), 32'hFFFF_FFFF);
          chk($sformatf("done_pulse d=%02h count", cur.data), 32'(done_hits), 32'd1);
          chk($sformatf("done_pulse d=%02h cycle", cur.data), 32'(done_at), 32'(fcyc - 1));
          in_frame = 0;
          last_end = cyc_no;
        end
      end
    end
  end

  logic [1:0]  c_db;
  logic        c_pen, c_podd, c_s2;
  logic [15:0] c_div;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pen, input logic podd,
                         input logic s2, input logic [15:0] div);
    c_db = db; c_pen = pen; c_podd = podd; c_s2 = s2; c_div = div;
    data_bits_i = db; parity_en_i = pen; parity_odd_i = podd; stop2_i = s2; baud_div_i = div;
  endtask

  task automatic write(input logic [7:0] d, input bit expect_frame);
    wr_if.tx_we = 1'b1;
    wr_if.din   = d;
    if (expect_frame) exp_q.push_back(make_frame(d, c_db, c_pen, c_podd, c_s2, c_div));
    step();
    wr_if.tx_we = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || busy_o) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    wr_if.tx_we = 1'b0;
    wr_if.din   = 8'h00;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    repeat (3) step();
    rst_i = 1'b0;
    chk("rst tx_o", 32'(tx_o), 32'd1);
    chk("rst empty", 32'(wr_if.empty), 32'd1);
    chk("rst full", 32'(wr_if.full), 32'd0);
    chk("rst level", 32'(wr_if.level), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst overflow", 32'(wr_if.overflow), 32'd0);

    // 8N1 div=4 0xA5 with write-to-line latency
    tx_en_i = 1'b1;
    write(8'hA5, 1);
    chk("lat empty_after_write", 32'(wr_if.empty), 32'd0);
    chk("lat tx_before_pop", 32'(tx_o), 32'd1);
    step();
    chk("lat tx_start", 32'(tx_o), 32'd0);
    chk("lat busy", 32'(busy_o), 32'd1);
    chk("lat empty_after_pop", 32'(wr_if.empty), 32'd1);
    drain(200);

    // 7E2 / 7O2 div=3 0x83, 5O1 div=1 0xFF
    set_cfg(2'd2, 1'b1, 1'b0, 1'b1, 16'd3); write(8'h83, 1); drain(200);
    set_cfg(2'd2, 1'b1, 1'b1, 1'b1, 16'd3); write(8'h83, 1); drain(200);
    set_cfg(2'd0, 1'b1, 1'b1, 1'b0, 16'd1); write(8'hFF, 1); drain(200);

    // Random configurations, 1-3 queued bytes each (div 0 included)
    for (int r = 0; r < 12; r++) begin
      int nbytes;
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom_range(0, 5)));
      nbytes = int'($urandom_range(1, 3));
      for (int i = 0; i < nbytes; i++) write(8'($urandom), 1);
      drain(1000);
    end

    // FIFO fill with transmitter held off, then back-to-back drain
    tx_en_i = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd2);
    for (int i = 0; i < 5; i++) begin
      write(8'(8'h10 + i), i < 4);
      chk($sformatf("fill level[%0d]", i), 32'(wr_if.level), 32'((i < 4) ? i + 1 : 4));
      chk($sformatf("fill full[%0d]", i), 32'(wr_if.full), 32'(i >= 3));
      chk($sformatf("fill overflow[%0d]", i), 32'(wr_if.overflow), 32'(i == 4));
    end
    step();
    chk("overflow single_pulse", 32'(wr_if.overflow), 32'd0);
    chk("held busy", 32'(busy_o), 32'd0);
    b0 = b2b;
    tx_en_i = 1'b1;
    drain(500);
    chk("b2b frames", 32'(b2b - b0), 32'd3);
    chk("drained empty", 32'(wr_if.empty), 32'd1);
    chk("drained busy", 32'(busy_o), 32'd0);

    // Config change mid-frame applies to the next frame only
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    write(8'h3C, 1);
    repeat (10) step();
    set_cfg(2'd1, 1'b0, 1'b0, 1'b0, 16'd2);
    write(8'hD7, 1);
    drain(300);

    // tx_en dropped mid-frame: frame finishes, queued byte stays
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    write(8'h5A, 1);
    repeat (6) step();
    tx_en_i = 1'b0;
    write(8'h11, 0);
    drain(300);
    repeat (40) step();
    chk("hold level", 32'(wr_if.level), 32'd1);
    chk("hold busy", 32'(busy_o), 32'd0);
    chk("hold tx", 32'(tx_o), 32'd1);

    // Reset during DATA with 3 bytes queued
    write(8'h22, 0); write(8'h33, 0); write(8'h44, 0);
    tx_en_i = 1'b1;
    exp_q.push_back(make_frame(8'h11, c_db, c_pen, c_podd, c_s2, c_div));
    step();
    chk("pre_rst queued", 32'(wr_if.level), 32'd3);
    repeat (8) step();
    rst_i = 1'b1;
    exp_q.delete();
    step();
    chk("midrst tx", 32'(tx_o), 32'd1);
    chk("midrst level", 32'(wr_if.level), 32'd0);
    chk("midrst busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    repeat (60) step();
    chk("postrst tx", 32'(tx_o), 32'd1);
    chk("postrst busy", 32'(busy_o), 32'd0);
    chk("stray done pulses", 32'(stray_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter. Successor to the fixed 8N1 transmitter.
- Adds selectable data length (5–8 bits), optional even/odd parity, and 1 or 2 stop bits.
- Bit-accurate baud timing: the baud counter restarts at every frame start.
- Contains an internal byte FIFO with level reporting, and raises a done pulse per frame. Sits in the UART peripheral between the register interface and the pad.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- LVL_W, $clog2(FIFO_DEPTH+1), width of level_o (derived, not overridden).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- baud_div_i  input  16  clocks per bit; 0 treated as 1
- data_bits_i  input  2  0→5, 1→6, 2→7, 3→8 data bits
- parity_en_i  input  1  1 = parity bit inserted after data
- parity_odd_i  input  1  1 = odd parity, 0 = even parity
- stop2_i  input  1  1 = two stop bits
- tx_en_i  input  1  permits starting new frames
- tx_we_i  input  1  FIFO write strobe
- din_i  input  8  write data
- full_o  output  1  FIFO full
- empty_o  output  1  FIFO empty
- level_o  output  LVL_W  FIFO occupancy
- overflow_o  output  1  one-cycle pulse: write dropped while full
- busy_o  output  1  frame in progress (state != IDLE)
- done_o  output  1  one-cycle pulse at end of the last stop bit
- tx_o  output  1  serial line, idle high

Behaviour:
- Reset (rst_i=1 at clk edge): FIFO emptied, state IDLE, counters 0.
  - Outputs after reset: tx_o=1, empty_o=1, full_o=0, level_o=0, busy_o=0, done_o=0, overflow_o=0.
  - Reset mid-frame aborts the frame; tx_o is 1 the next cycle.
- FIFO:
  - Write accepted when tx_we_i && !full_o.
  - Write while full is dropped and overflow_o pulses the following cycle. No write-through, even with a same-cycle pop.
  - Simultaneous accepted write and pop leaves level_o unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full_o, empty_o and level_o are registered-count derived, valid the cycle after the edge.
- State machine IDLE → START → DATA → [PARITY] → STOP → IDLE/START.
  - IDLE, tx_o=1:
    - If !empty_o && tx_en_i, pop the FIFO head into the shift register.
    - On the same edge, latch data_bits_i, parity_en_i, parity_odd_i, stop2_i and baud_div_i into shadow registers. Config changes mid-frame have no effect.
    - Next state START.
  - START: tx_o=0 for exactly div cycles (div = latched baud_div, min 1).
  - DATA: LSB first, each bit div cycles. Sends N = 5..8 bits; din_i bits above N-1 are ignored.
  - PARITY (only if latched parity_en):
    - Even: tx_o = XOR of the N sent bits.
    - Odd: tx_o = inverted XOR of the N sent bits.
    - div cycles.
  - STOP: tx_o=1 for div or 2·div cycles.
    - On its final cycle, done_o=1.
    - If FIFO non-empty and tx_en_i=1, pop and go directly to START (back-to-back, no idle cycle). Otherwise go to IDLE.
- Baud counter:
  - Reset to 0 on every state entry; counts 0..div-1.
  - A bit ends when count==div-1.
  - Bit counter indexes 0..N-1 in DATA and 0..1 in STOP.
- Latency: a write into an empty FIFO with tx_en_i=1 at edge k gives empty_o=0 after k. IDLE pops at edge k+1, and tx_o=0 from edge k+1.
- tx_en_i deasserted mid-frame: the current frame completes; no new frame starts. While tx_en_i=0 in IDLE, the FIFO still accepts writes.
- Frame length in clocks: div·(1 + N + parity_en + 1 + stop2).
- busy_o=1 in every state except IDLE.

Test Plan:
- 8N1, div=4, write 0xA5 → tx_o: 0 (4 clk), then 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk). done_o pulses once at clk 40 after start. Frame is 40 clk.
- 7E2, div=3, write 0x83 → 7 data bits 1,1,0,0,0,0,0, then parity 0, then 6 clk high. Frame is 33 clk. Repeat with odd parity → parity bit 1.
- 5O1, div=1, write 0xFF → bits 1×5, parity 0, stop 1. Frame is 8 clk. Bits 7:5 of din_i do not appear on tx_o.
- FIFO_DEPTH=4, tx_en_i=0, write 5 bytes → level_o 1,2,3,4,4; full_o=1 after 4th; overflow_o pulses once on the 5th. Raise tx_en_i → 4 back-to-back frames with no idle gap, then empty_o=1 and busy_o=0.
- Mid-frame changes:
  - Change data_bits_i and baud_div_i during DATA → current frame is unchanged; the next frame uses the new values.
  - Drop tx_en_i mid-frame → current frame finishes and the line stays idle.
- Assert rst_i during DATA with 3 bytes queued → next cycle tx_o=1, level_o=0, busy_o=0. No frame resumes after reset release.
